data_memory: RTL
================

// Module: data_memory
// PURPOSE
//   Multi-cycle data memory that serves the CPU's load/store port: the CPU initiates,
//   this block responds. It accepts one READ or WRITE request at a time and stalls the
//   CPU with BUSYWAIT for a fixed access latency, then commits the write or returns
//   READDATA. It sits beside the register file/ALU datapath, behind the CPU data port.
// PARAMETERS
//   ADDR_W   8    address width; memory depth = 2**ADDR_W words
//   DATA_W   8    word width (matches register file / ALU width)
//   LATENCY  5    posedges from request acceptance to completion; legal range 2..15
// PORTS
//   CLK        in   1        clock; all state changes on posedge
//   RESET_N    in   1        asynchronous reset, active-low
//   READ       in   1        load request, held by CPU until BUSYWAIT falls
//   WRITE      in   1        store request, held by CPU until BUSYWAIT falls
//   ADDRESS    in   ADDR_W   word address, stable while request held
//   WRITEDATA  in   DATA_W   store data, stable while WRITE held
//   READDATA   out  DATA_W   load result, registered
//   BUSYWAIT   out  1        stall to CPU; high while a request is pending
// BEHAVIOUR
//   Reset (RESET_N=0, async): state=IDLE, counter=0, READDATA=0, BUSYWAIT=0.
//     Memory array contents are NOT cleared. In-flight access is aborted: no write
//     commit, READDATA stays 0. Leaving reset: first posedge sees IDLE.
//   FSM states: IDLE, BUSY, DONE.
//     IDLE: if READ|WRITE at posedge t0 -> latch op, ADDRESS, WRITEDATA; go BUSY;
//           load counter. Else stay IDLE.
//     BUSY: counter advances each posedge. At posedge t0+LATENCY: WRITE -> mem[addr]
//           <= data; READ -> READDATA <= mem[addr]; go DONE.
//     DONE: exactly one cycle; requests ignored; next posedge -> IDLE.
//   BUSYWAIT (combinational from state and inputs):
//     = (state==IDLE & (READ|WRITE)) | (state==BUSY). Low in DONE.
//     Asserts in the same cycle the request appears; falls right after posedge
//     t0+LATENCY. The CPU sees exactly LATENCY stall edges per access.
//   Latched values are used for the commit. Input changes after t0 are ignored
//   until the next acceptance.
//   READ and WRITE both high at acceptance: treated as WRITE; READDATA unchanged.
//   Request dropped mid-BUSY: access still completes; no abort except reset.
//   READDATA holds its last load result across writes and idle cycles.
//   Back-to-back requests: a request still high in DONE is not accepted. It is
//     accepted at the following posedge in IDLE. Min request spacing = LATENCY+2.
//   Address covers the full 2**ADDR_W range; no out-of-range case, no wrap logic.
//   Write to an address followed by a read of that address returns the new data.
// TESTING
//   1 Reset: RESET_N=0 mid-sim -> READDATA=0, BUSYWAIT=0 immediately (no clock edge).
//   2 Store: WRITE=1, ADDRESS=8'h10, WRITEDATA=8'hA5 -> BUSYWAIT=1 same cycle and
//     for 5 edges, then low. Then READ addr 8'h10 -> READDATA=8'hA5 after 5 edges.
//   3 Latency count: READ addr 8'h00 after reset -> exactly LATENCY posedges with
//     BUSYWAIT=1; repeat with LATENCY=2 and LATENCY=15 builds.
//   4 Simultaneous READ=1 and WRITE=1, addr 8'h20, data 8'h3C -> mem[8'h20]=8'h3C;
//     READDATA keeps its prior value 8'hA5.
//   5 Abort: WRITE addr 8'h30 data 8'hFF; pulse RESET_N low at edge 3 -> BUSYWAIT=0.
//     A later READ of 8'h30 returns the pre-existing contents, not 8'hFF.
//   6 Back-to-back: hold READ high through DONE -> second access begins one cycle
//     after DONE. BUSYWAIT shows a single low cycle between the two accesses.

Source files
------------

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//   Multi-cycle data memory behind the CPU load/store port. One READ or WRITE
//   request is accepted at a time. The CPU is stalled with o_busywait for
//   LATENCY posedges. After that the latched write is committed, or the load
//   result is registered onto o_readdata.
//
// Parameters
//   ADDR_W   address width, memory depth = 2**ADDR_W words
//   DATA_W   word width
//   LATENCY  posedges from acceptance to completion, legal range 2..15
//
// Ports
//   i_clk         clock, all state changes on posedge
//   i_reset_n     asynchronous reset, active-low (memory contents kept)
//   i_read        load request, held until o_busywait falls
//   i_write       store request, held until o_busywait falls
//   i_address     word address
//   i_writedata   store data
//   o_readdata    registered load result
//   o_busywait    stall to CPU, high while a request is pending
// -----------------------------------------------------------------------------
module data_memory #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 5
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [DATA_W-1:0] i_writedata,
  output logic [DATA_W-1:0] o_readdata,
  output logic              o_busywait
);

  localparam int DEPTH = 1 << ADDR_W;
  // The counter is loaded at acceptance. It reaches zero on the posedge
  // before completion, so the commit lands exactly LATENCY posedges after
  // acceptance.
  localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_count;
  logic              r_is_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_readdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_request;
  logic w_finish;
  logic w_commit_write;

  assign w_request      = i_read | i_write;
  assign w_finish       = (r_state == ST_BUSY) && (r_count == 4'd0);
  assign w_commit_write = w_finish & r_is_write;

  // Control FSM.
  // When READ and WRITE are both high at acceptance, the request is latched
  // as a write, so READDATA is left untouched for that access.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_count    <= 4'd0;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_readdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_request) begin
            r_state    <= ST_BUSY;
            r_count    <= COUNT_LOAD;
            r_is_write <= i_write;
            r_addr     <= i_address;
            r_wdata    <= i_writedata;
          end
        end
        ST_BUSY: begin
          if (r_count == 4'd0) begin
            r_state <= ST_DONE;
            if (!r_is_write) begin
              r_readdata <= r_mem[r_addr];
            end
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        ST_DONE: begin
          // Single recovery cycle. A request still held here is taken only
          // on the next posedge, once the FSM is back in IDLE.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Storage array, not reset. A reset mid-access forces IDLE at once,
  // which drops w_commit_write, so an aborted store never lands.
  always_ff @(posedge i_clk) begin
    if (w_commit_write) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign o_readdata = r_readdata;

  // The stall rises in the same cycle the request appears. It is forced low
  // while reset is held, so the CPU is released immediately.
  assign o_busywait = i_reset_n &
                      (((r_state == ST_IDLE) & w_request) | (r_state == ST_BUSY));

endmodule
